// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared types and default widths for the clock-divider sequencer.
//   mode_e  : configuration mode encoding carried on cfg_mode.
//   state_e : sequencer FSM states.
package div_seq_pkg;

   localparam int CNT_W_DEF   = 32;
   localparam int BURST_W_DEF = 16;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      FREE  = 2'd1,
      BURST = 2'd2,
      RSVD  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      BURST_S = 2'd2
   } state_e;

endpackage

// File: rtl/div_seq_counter.sv
// div_counter: programmable period counter for the divider datapath.
//   clk, rst   : clock, synchronous active-high reset
//   en         : count this cycle (sequencer in RUN/BURST)
//   load       : restart the count at 0 (a new configuration is applied)
//   period     : cycles per tick; terminal count is period-1
//   force_low  : hold div_out low and count at 0 (sequencer idle)
//   wrap       : combinational terminal-count flag for this cycle
//   tick       : registered one-cycle strobe, set on the wrap edge
//   div_out    : registered output, inverts on every wrap edge
module div_counter
   import div_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] period,
   input  logic             force_low,
   output logic             wrap,
   output logic             tick,
   output logic             div_out
);

   logic [CNT_W-1:0] r_count;
   logic             r_tick;
   logic             r_div;
   logic             w_wrap;

   assign w_wrap  = en && (r_count == period - CNT_W'(1));
   assign wrap    = w_wrap;
   assign tick    = r_tick;
   assign div_out = r_div;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_tick  <= 1'b0;
         r_div   <= 1'b0;
      end else begin
         r_tick <= w_wrap;
         // The wrap toggle takes priority so the final tick of a run still
         // toggles; the forced clear lands one cycle after entering idle.
         if (w_wrap)
            r_div <= ~r_div;
         else if (force_low)
            r_div <= 1'b0;

         if (load || w_wrap || force_low)
            r_count <= '0;
         else if (en)
            r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: sequences the divider counter through stop, free-run and
// fixed-length burst modes. Configuration is taken over a valid/ready
// handshake into a shadow register and applied only at a terminal count
// (or immediately when idle), so div_out never produces a runt half-period.
//   clk, rst             : clock, synchronous active-high reset
//   cfg_valid/cfg_ready  : configuration handshake (ready low while shadow pending)
//   cfg_mode             : 0=STOP 1=FREE 2=BURST 3=reserved(STOP)
//   cfg_period           : cycles per tick (0 treated as 1)
//   cfg_burst            : number of ticks in BURST mode
//   tick, div_out        : terminal-count strobe and 50% divided output
//   busy                 : state is RUN or BURST_S
//   done                 : one-cycle pulse when a burst completes
// Optional status (macro DIV_SEQ_STATUS_EN):
//   tick_cnt             : saturating ticks since the last applied config
//   cfg_rej              : pulse when cfg_valid is seen while cfg_ready is low
//
// state   | meaning
// IDLE    | counter stopped at 0, div_out low; applies a pending shadow next cycle
// RUN     | free-running; leaves only through an applied shadow
// BURST_S | counting ticks down from cfg_burst; returns to IDLE after the last
module div_sequencer
   import div_seq_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int BURST_W    = BURST_W_DEF,
   parameter int RST_PERIOD = 10000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [1:0]         cfg_mode,
   input  logic [CNT_W-1:0]   cfg_period,
   input  logic [BURST_W-1:0] cfg_burst,
   output logic               tick,
   output logic               div_out,
   output logic               busy,
   output logic               done
`ifdef DIV_SEQ_STATUS_EN
   ,
   output logic [31:0]        tick_cnt,
   output logic               cfg_rej
`endif
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic               r_pend;
   mode_e              r_sh_mode;
   logic [CNT_W-1:0]   r_sh_period;
   logic [BURST_W-1:0] r_sh_burst;
   logic [CNT_W-1:0]   r_period;
   logic [BURST_W-1:0] r_remaining;
   logic               r_done;

   logic               w_xfer;
   logic               w_apply;
   logic               w_done_nxt;
   logic               w_wrap;
   logic               w_en;
   logic               w_force_low;

   assign w_xfer      = cfg_valid && !r_pend;
   assign w_en        = (r_state != IDLE);
   assign w_force_low = (r_state == IDLE);

   assign cfg_ready = !r_pend;
   assign busy      = (r_state != IDLE);
   assign done      = r_done;

   div_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk       (clk),
      .rst       (rst),
      .en        (w_en),
      .load      (w_apply),
      .period    (r_period),
      .force_low (w_force_low),
      .wrap      (w_wrap),
      .tick      (tick),
      .div_out   (div_out)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_apply     = 1'b0;
      w_done_nxt  = 1'b0;

      case (r_state)
         IDLE:    w_apply = r_pend;
         RUN:     w_apply = r_pend && w_wrap;
         BURST_S: begin
            w_apply = r_pend && w_wrap;
            if (w_wrap && (r_remaining == BURST_W'(1))) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // A pending shadow overrides the burst-complete return to IDLE; done
      // from the completed burst is kept.
      if (w_apply) begin
         case (r_sh_mode)
            FREE:  w_state_nxt = RUN;
            BURST: begin
               if (r_sh_burst != '0) begin
                  w_state_nxt = BURST_S;
               end else begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend      <= 1'b0;
         r_sh_mode   <= STOP;
         r_sh_period <= CNT_W'(1);
         r_sh_burst  <= '0;
         r_period    <= CNT_W'(RST_PERIOD);
         r_remaining <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_done_nxt;

         if (w_apply) begin
            r_pend   <= 1'b0;
            r_period <= r_sh_period;
         end else if (w_xfer) begin
            r_pend      <= 1'b1;
            r_sh_mode   <= mode_e'(cfg_mode);
            r_sh_period <= (cfg_period == '0) ? CNT_W'(1) : cfg_period;
            r_sh_burst  <= cfg_burst;
         end

         if (w_apply && (r_sh_mode == BURST))
            r_remaining <= r_sh_burst;
         else if ((r_state == BURST_S) && w_wrap)
            r_remaining <= r_remaining - BURST_W'(1);
      end
   end

`ifdef DIV_SEQ_STATUS_EN
   logic [31:0] r_tick_cnt;
   logic        r_rej;

   assign tick_cnt = r_tick_cnt;
   assign cfg_rej  = r_rej;

   // Counts the same wrap events that raise tick; an apply edge clears it
   // even though that edge's tick belongs to the outgoing configuration.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt <= '0;
         r_rej      <= 1'b0;
      end else begin
         r_rej <= cfg_valid && !r_pend;
         r_rej <= cfg_valid && r_pend;
         if (w_apply)
            r_tick_cnt <= '0;
         else if (w_wrap && (r_tick_cnt != '1))
            r_tick_cnt <= r_tick_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

   localparam longint RST_P = 10000000;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_mode;
   logic [31:0] cfg_period;
   logic [15:0] cfg_burst;
   logic        tick;
   logic        div_out;
   logic        busy;
   logic        done;
`ifdef DIV_SEQ_STATUS_EN
   logic [31:0] tick_cnt;
   logic        cfg_rej;
`endif

   always #5 clk = ~clk;

   div_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_burst  (cfg_burst),
      .tick       (tick),
      .div_out    (div_out),
      .busy       (busy),
      .done       (done)
`ifdef DIV_SEQ_STATUS_EN
      ,
      .tick_cnt   (tick_cnt),
      .cfg_rej    (cfg_rej)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: tracks "cycles elapsed since the last period boundary"
   // and "ticks still owed to the burst", rather than any counter encoding.
   bit     m_active, m_is_burst, m_pend, m_div, m_tick, m_done, m_ready, m_rej;
   longint m_per, m_since, m_tickcnt, sh_per;
   int     m_left, sh_burst;
   bit [1:0] sh_mode;

   task automatic model_step();
      bit xfer, was_active, boundary;
      if (rst) begin
         m_active = 0; m_is_burst = 0; m_pend = 0; m_div = 0; m_tick = 0;
         m_done = 0; m_ready = 1; m_rej = 0; m_per = RST_P; m_since = 0;
         m_tickcnt = 0; m_left = 0;
         return;
      end
      xfer       = cfg_valid && !m_pend;
      m_rej      = cfg_valid && m_pend;
      was_active = m_active;
      boundary   = 0;
      m_tick     = 0;
      m_done     = 0;
      if (m_active) begin
         m_since++;
         if (m_since >= m_per) begin
            m_tick   = 1;
            m_div    = !m_div;
            m_since  = 0;
            boundary = 1;
            if (m_tickcnt < 64'hFFFF_FFFF) m_tickcnt++;
            if (m_is_burst) begin
               m_left--;
               if (m_left == 0) begin
                  m_done   = 1;
                  m_active = 0;
               end
            end
         end
      end else begin
         m_div = 0;
      end
      if (m_pend && (!was_active || boundary)) begin
         m_pend    = 0;
         m_per     = sh_per;
         m_since   = 0;
         m_tickcnt = 0;
         case (sh_mode)
            2'd1: begin m_active = 1; m_is_burst = 0; end
            2'd2: begin
               if (sh_burst > 0) begin
                  m_active = 1; m_is_burst = 1; m_left = sh_burst;
               end else begin
                  m_active = 0; m_done = 1;
               end
            end
            default: m_active = 0;
         endcase
      end
      if (xfer) begin
         m_pend   = 1;
         sh_mode  = cfg_mode;
         sh_per   = (cfg_period == 0) ? 1 : longint'(cfg_period);
         sh_burst = int'(cfg_burst);
      end
      m_ready = !m_pend;
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      chk("tick",    {31'd0, tick},      {31'd0, m_tick});
      chk("div_out", {31'd0, div_out},   {31'd0, m_div});
      chk("busy",    {31'd0, busy},      {31'd0, m_active});
      chk("done",    {31'd0, done},      {31'd0, m_done});
      chk("ready",   {31'd0, cfg_ready}, {31'd0, m_ready});
`ifdef DIV_SEQ_STATUS_EN
      chk("tick_cnt", tick_cnt, m_tickcnt[31:0]);
      chk("cfg_rej",  {31'd0, cfg_rej}, {31'd0, m_rej});
`endif
   end

   task automatic send(input logic [1:0] m, input logic [31:0] p, input logic [15:0] b);
      int n = 0;
      while (!cfg_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", {31'd0, cfg_ready}, 32'd1);
      cfg_valid  = 1'b1;
      cfg_mode   = m;
      cfg_period = p;
      cfg_burst  = b;
      @(negedge clk);
      cfg_valid  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int nt, nd, ntd, n;
      rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_period = 32'd0; cfg_burst = 16'd0;
      idle(3);
      chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
      chk("rst_busy",  {31'd0, busy},      32'd0);
      rst = 1'b0;
      idle(2);

      // free-run period 4, then stop
      send(2'd1, 32'd4, 16'd0);
      idle(20);
      send(2'd0, 32'd4, 16'd0);
      idle(8);

      // burst period 3 x5
      send(2'd2, 32'd3, 16'd5);
      nt = 0; nd = 0; ntd = 0;
      repeat (25) begin
         @(negedge clk);
         if (tick) nt++;
         if (done) nd++;
         if (tick && done) ntd++;
      end
      chk("burst_ticks", nt, 5);
      chk("burst_done", nd, 1);
      chk("burst_done_with_tick", ntd, 1);
      chk("burst_end_busy", {31'd0, busy}, 32'd0);
      chk("burst_end_div", {31'd0, div_out}, 32'd0);

      // period change mid-count
      send(2'd1, 32'd10, 16'd0);
      idle(3);
      send(2'd1, 32'd2, 16'd0);
      idle(20);
      send(2'd0, 32'd2, 16'd0);
      idle(6);

      // period 0 clamps to 1, then zero-length burst
      send(2'd1, 32'd0, 16'd0);
      idle(6);
      send(2'd2, 32'd0, 16'd0);
      idle(6);

      // reset mid-burst with a pending shadow
      send(2'd2, 32'd3, 16'd4);
      nt = 0; n = 0;
      while (nt < 2 && n < 50) begin
         @(negedge clk);
         if (tick) nt++;
         n++;
      end
      chk("burst_two_ticks", nt, 2);
      send(2'd1, 32'd5, 16'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_done",  {31'd0, done},      32'd0);
      chk("abort_ready", {31'd0, cfg_ready}, 32'd1);
      chk("abort_busy",  {31'd0, busy},      32'd0);
      chk("abort_tick",  {31'd0, tick},      32'd0);
      idle(4);

`ifdef DIV_SEQ_STATUS_EN
      send(2'd1, 32'd2, 16'd0);
      idle(21);
      chk("tick_cnt_20", tick_cnt, 32'd10);
      send(2'd0, 32'd2, 16'd0);
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("cfg_rej_pulse", {31'd0, cfg_rej}, 32'd1);
      idle(6);
`endif

      // randomized traffic, including rejected requests and stray resets
      repeat (1500) begin
         rst        = ($urandom_range(0, 99) == 0);
         cfg_valid  = ($urandom_range(0, 4) == 0);
         cfg_mode   = 2'($urandom_range(0, 3));
         cfg_period = $urandom_range(0, 6);
         cfg_burst  = 16'($urandom_range(0, 4));
         @(negedge clk);
      end
      rst = 1'b0;
      cfg_valid = 1'b0;
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
